// File: rtl/window_accumulator.sv
// window_accumulator: per-frame, per-channel statistics over windowed samples.
// Three select-mask streams mark which beats fall in each channel's window;
// for every channel the in-window sum, count and signed peak are built up over
// a FRAME_LEN-beat frame and published together with a one-cycle strobe.
module window_accumulator #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DW-1:0]          sample_data,
    input  logic                          sample_valid,
    input  logic                          sel_1,
    input  logic                          sel_2,
    input  logic                          sel_3,
    input  logic                          sel_en_1,
    input  logic                          sel_en_2,
    input  logic                          sel_en_3,
    input  logic                          ch3_error,
    output logic signed [DW+7:0]          sum_1,
    output logic signed [DW+7:0]          sum_2,
    output logic signed [DW+7:0]          sum_3,
    output logic [$clog2(FRAME_LEN):0]    cnt_1,
    output logic [$clog2(FRAME_LEN):0]    cnt_2,
    output logic [$clog2(FRAME_LEN):0]    cnt_3,
    output logic signed [DW-1:0]          max_1,
    output logic signed [DW-1:0]          max_2,
    output logic signed [DW-1:0]          max_3,
    output logic                          ch3_ok,
    output logic                          align_err,
    output logic                          result_valid
);

    localparam int CW   = $clog2(FRAME_LEN);
    localparam int CNTW = CW + 1;
    localparam int SW   = DW + 8;
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t          state_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic            align_reg;
    logic            align_next;
    logic            ch3_err_reg;
    logic            ch3_err_next;
    logic            ch3_ok_reg;
    logic            align_err_reg;
    logic            result_valid_reg;

    logic            beat;
    logic            frame_start;
    logic            frame_close;
    logic            misalign_now;
    logic [2:0]      sel_v;
    logic [2:0]      sel_en_v;

    logic signed [SW-1:0] sum_arr [3];
    logic [CNTW-1:0]      cnt_arr [3];
    logic signed [DW-1:0] max_arr [3];

    assign beat        = sample_valid;
    assign frame_start = beat && (state_reg == IDLE);
    assign frame_close = beat && (state_reg == ACCUM) && (beat_cnt_reg == CW'(FRAME_LEN - 1));
    assign sel_v       = {sel_3, sel_2, sel_1};
    assign sel_en_v    = {sel_en_3, sel_en_2, sel_en_1};

    // A beat missing any mask-valid, or a mask-valid with no beat, is misaligned.
    assign misalign_now = beat ? ~(&sel_en_v) : (|sel_en_v);

    // Working frame flags: the start beat reloads them from its own contribution.
    always_comb begin
        align_next   = align_reg | misalign_now;
        ch3_err_next = ch3_err_reg;
        if (frame_start) begin
            align_next   = misalign_now;
            ch3_err_next = ch3_error;
        end else if (state_reg == ACCUM) begin
            ch3_err_next = ch3_err_reg | ch3_error;
        end
    end

    // Frame FSM, beat counter, working flags and the published status/strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            beat_cnt_reg     <= '0;
            align_reg        <= 1'b0;
            ch3_err_reg      <= 1'b0;
            ch3_ok_reg       <= 1'b1;
            align_err_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            align_reg        <= align_next;
            ch3_err_reg      <= ch3_err_next;
            result_valid_reg <= frame_close;
            if (beat) begin
                beat_cnt_reg <= frame_close ? '0 : beat_cnt_reg + CW'(1);
            end
            case (state_reg)
                IDLE:    if (frame_start) state_reg <= ACCUM;
                ACCUM:   if (frame_close) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (frame_close) begin
                ch3_ok_reg    <= ~ch3_err_next;
                align_err_reg <= align_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic                 in_win;
            logic signed [SW-1:0] sample_ext;
            logic signed [SW-1:0] sum_reg, sum_next, sum_out_reg;
            logic [CNTW-1:0]      cnt_reg, cnt_next, cnt_out_reg;
            logic signed [DW-1:0] max_reg, max_next, max_out_reg;

            assign in_win     = beat & sel_en_v[gi] & sel_v[gi];
            assign sample_ext = {{8{sample_data[DW-1]}}, sample_data};

            // Next working values: reload on the start beat, accumulate afterwards.
            always_comb begin
                sum_next = sum_reg;
                cnt_next = cnt_reg;
                max_next = max_reg;
                if (frame_start) begin
                    sum_next = in_win ? sample_ext : '0;
                    cnt_next = {{(CNTW-1){1'b0}}, in_win};
                    max_next = in_win ? sample_data : MOST_NEG;
                end else if (in_win) begin
                    sum_next = sum_reg + sample_ext;
                    cnt_next = cnt_reg + CNTW'(1);
                    if (sample_data > max_reg) begin
                        max_next = sample_data;
                    end
                end
            end

            // Working accumulators every cycle; output copy on the closing beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_reg     <= '0;
                    cnt_reg     <= '0;
                    max_reg     <= MOST_NEG;
                    sum_out_reg <= '0;
                    cnt_out_reg <= '0;
                    max_out_reg <= MOST_NEG;
                end else begin
                    sum_reg <= sum_next;
                    cnt_reg <= cnt_next;
                    max_reg <= max_next;
                    if (frame_close) begin
                        sum_out_reg <= sum_next;
                        cnt_out_reg <= cnt_next;
                        max_out_reg <= max_next;
                    end
                end
            end

            assign sum_arr[gi] = sum_out_reg;
            assign cnt_arr[gi] = cnt_out_reg;
            assign max_arr[gi] = max_out_reg;
        end
    endgenerate

    assign sum_1        = sum_arr[0];
    assign sum_2        = sum_arr[1];
    assign sum_3        = sum_arr[2];
    assign cnt_1        = cnt_arr[0];
    assign cnt_2        = cnt_arr[1];
    assign cnt_3        = cnt_arr[2];
    assign max_1        = max_arr[0];
    assign max_2        = max_arr[1];
    assign max_3        = max_arr[2];
    assign ch3_ok       = ch3_ok_reg;
    assign align_err    = align_err_reg;
    assign result_valid = result_valid_reg;

endmodule
